// File: rtl/ad_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Default widths and the writeback source tag encoding.
package ad_wb_arbiter_pkg;

   localparam int DEF_REG_DATA_WIDTH     = 32;
   localparam int DEF_REGFILE_ADDR_WIDTH = 5;
   localparam int DEF_REGFILE_DEPTH      = 32;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MAC = 1'b1
   } wb_src_e;

endpackage

// File: rtl/ad_wb_arbiter_if.sv
// Writeback bus: ALU/MAC result handshakes, MAC issue,
// scoreboard and regfile write port.
import ad_wb_arbiter_pkg::*;

interface ad_wb_arbiter_if #(
   parameter int REG_DATA_WIDTH     = DEF_REG_DATA_WIDTH,
   parameter int REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
   parameter int REGFILE_DEPTH      = DEF_REGFILE_DEPTH
);

   logic                          alu_valid_i;
   logic                          alu_ready_o;
   logic [REGFILE_ADDR_WIDTH-1:0] alu_rd_addr_i;
   logic [REG_DATA_WIDTH-1:0]     alu_rd_data_i;

   logic                          mac_valid_i;
   logic                          mac_ready_o;
   logic [REGFILE_ADDR_WIDTH-1:0] mac_rd_addr_i;
   logic [REG_DATA_WIDTH-1:0]     mac_rd_data_i;

   logic                          issue_mac_en_i;
   logic [REGFILE_ADDR_WIDTH-1:0] issue_mac_addr_i;
   logic [REGFILE_DEPTH-1:0]      busy_vec_o;

   logic [REGFILE_ADDR_WIDTH-1:0] rd_addr_o;
   logic [REG_DATA_WIDTH-1:0]     rd_wr_data_o;
   logic                          rd_wr_en_o;

   modport slave (
      input  alu_valid_i,
      output alu_ready_o,
      input  alu_rd_addr_i,
      input  alu_rd_data_i,
      input  mac_valid_i,
      output mac_ready_o,
      input  mac_rd_addr_i,
      input  mac_rd_data_i,
      input  issue_mac_en_i,
      input  issue_mac_addr_i,
      output busy_vec_o,
      output rd_addr_o,
      output rd_wr_data_o,
      output rd_wr_en_o
   );

   modport master (
      output alu_valid_i,
      input  alu_ready_o,
      output alu_rd_addr_i,
      output alu_rd_data_i,
      output mac_valid_i,
      input  mac_ready_o,
      output mac_rd_addr_i,
      output mac_rd_data_i,
      output issue_mac_en_i,
      output issue_mac_addr_i,
      input  busy_vec_o,
      input  rd_addr_o,
      input  rd_wr_data_o,
      input  rd_wr_en_o
   );

endinterface

// File: rtl/ad_wb_fifo.sv
// Parameterised synchronous FIFO with full/empty/count.
// Push when full and pop when empty are ignored.
module ad_wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Power-of-two depth: pointers wrap naturally on overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/ad_wb_arbiter.sv
// Regfile write-port arbiter: ALU vs buffered MAC results,
// with anti-starvation, x0 suppression and MAC scoreboard.
import ad_wb_arbiter_pkg::*;

module ad_wb_arbiter #(
   parameter int REG_DATA_WIDTH     = DEF_REG_DATA_WIDTH,
   parameter int REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
   parameter int REGFILE_DEPTH      = DEF_REGFILE_DEPTH,
   parameter int FIFO_DEPTH         = 4,
   parameter int STARVE_LIMIT       = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   ad_wb_arbiter_if.slave  bus
);

   localparam int AW = REGFILE_ADDR_WIDTH;
   localparam int DW = REG_DATA_WIDTH;
   localparam int EW = AW + DW;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [EW-1:0] head;
   logic          full, empty;
   logic [CW-1:0] fifo_cnt;

   logic          push, pop, alu_xfer, force_w;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;
   wb_src_e       win_src;

   logic [SW-1:0]            starve_q, starve_d;
   logic                     wr_en_q, wr_en_d;
   logic [AW-1:0]            addr_q, addr_d;
   logic [DW-1:0]            data_q, data_d;
   wb_src_e                  src_q, src_d;
   logic [REGFILE_DEPTH-1:0] busy_q, busy_d;

   assign force_w  = (starve_q == SW'(STARVE_LIMIT));
   assign alu_xfer = bus.alu_valid_i && !force_w;
   assign push     = bus.mac_valid_i && !full;
   assign pop      = !alu_xfer && !empty;

   assign bus.alu_ready_o  = !force_w;
   assign bus.mac_ready_o  = !full;
   assign bus.busy_vec_o   = busy_q;
   assign bus.rd_addr_o    = addr_q;
   assign bus.rd_wr_data_o = data_q;
   assign bus.rd_wr_en_o   = wr_en_q;

   ad_wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .wdata_i ({bus.mac_rd_addr_i, bus.mac_rd_data_i}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fifo_cnt)
   );

   // alu_xfer is impossible at the limit, so the count saturates there.
   always_comb begin
      starve_d = starve_q;
      if (pop || fifo_cnt == '0)
         starve_d = '0;
      else if (alu_xfer)
         starve_d = starve_q + 1'b1;
   end

   always_comb begin
      win_addr = alu_xfer ? bus.alu_rd_addr_i : head[EW-1 -: AW];
      win_data = alu_xfer ? bus.alu_rd_data_i : head[DW-1:0];
      win_src  = alu_xfer ? WB_ALU : WB_MAC;
      wr_en_d  = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      src_d    = src_q;
      if ((alu_xfer || pop) && win_addr != '0) begin
         wr_en_d = 1'b1;
         addr_d  = win_addr;
         data_d  = win_data;
         src_d   = win_src;
      end
   end

   // Clear on the driven MAC write, then set so a re-issue wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_en_q && src_q == WB_MAC)
         busy_d[addr_q] = 1'b0;
      if (bus.issue_mac_en_i && bus.issue_mac_addr_i != '0)
         busy_d[bus.issue_mac_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_q <= '0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         src_q    <= WB_ALU;
         busy_q   <= '0;
      end else begin
         starve_q <= starve_d;
         wr_en_q  <= wr_en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         src_q    <= src_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: tb/tb_ad_wb_arbiter.sv
// Directed bench for ad_wb_arbiter: ALU path, x0, MAC path,
// starvation, FIFO wrap and asynchronous reset mid-drain.
module tb_ad_wb_arbiter;
   import ad_wb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ad_wb_arbiter_if bus ();

   ad_wb_arbiter dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic idle_inputs();
      bus.alu_valid_i      = 1'b0;
      bus.alu_rd_addr_i    = '0;
      bus.alu_rd_data_i    = '0;
      bus.mac_valid_i      = 1'b0;
      bus.mac_rd_addr_i    = '0;
      bus.mac_rd_data_i    = '0;
      bus.issue_mac_en_i   = 1'b0;
      bus.issue_mac_addr_i = '0;
   endtask

   task automatic test_reset();
      logic [37:0] wb;
      rst = 1'b1;
      idle_inputs();
      #2;
      wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
      checks++;
      if (wb !== 38'h0) begin
         errors++;
         $display("FAIL reset_wb: got %h exp %h", wb, 38'h0);
      end
      checks++;
      if (bus.busy_vec_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_busy: got %h exp 0", bus.busy_vec_o);
      end
      checks++;
      if ({bus.alu_ready_o, bus.mac_ready_o} !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready: got %b exp 11",
                  {bus.alu_ready_o, bus.mac_ready_o});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_alu_write();
      logic [37:0] wb;
      @(negedge clk);
      bus.alu_valid_i   = 1'b1;
      bus.alu_rd_addr_i = 5'd5;
      bus.alu_rd_data_i = 32'hDEADBEEF;
      checks++;
      if (bus.alu_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL alu_ready: got %b exp 1", bus.alu_ready_o);
      end
      @(negedge clk);
      bus.alu_valid_i = 1'b0;
      wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
      checks++;
      if (wb !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL alu_write: got %h exp %h", wb,
                  {1'b1, 5'd5, 32'hDEADBEEF});
      end
      checks++;
      if (bus.busy_vec_o !== 32'h0) begin
         errors++;
         $display("FAIL alu_busy: got %h exp 0", bus.busy_vec_o);
      end
   endtask

   task automatic test_x0();
      logic [37:0] wb;
      @(negedge clk);
      bus.alu_valid_i   = 1'b1;
      bus.alu_rd_addr_i = 5'd0;
      bus.alu_rd_data_i = 32'h55;
      checks++;
      if (bus.alu_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL x0_ready: got %b exp 1", bus.alu_ready_o);
      end
      @(negedge clk);
      bus.alu_valid_i = 1'b0;
      wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
      checks++;
      if (wb !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL x0_suppress: got %h exp %h", wb,
                  {1'b0, 5'd5, 32'hDEADBEEF});
      end
   endtask

   task automatic test_mac_single();
      logic [37:0] wb;
      @(negedge clk);
      bus.issue_mac_en_i   = 1'b1;
      bus.issue_mac_addr_i = 5'd7;
      @(negedge clk);
      bus.issue_mac_en_i = 1'b0;
      checks++;
      if (bus.busy_vec_o !== 32'h80) begin
         errors++;
         $display("FAIL mac_busy_set: got %h exp 80", bus.busy_vec_o);
      end
      bus.mac_valid_i   = 1'b1;
      bus.mac_rd_addr_i = 5'd7;
      bus.mac_rd_data_i = 32'h1234;
      checks++;
      if (bus.mac_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL mac_ready: got %b exp 1", bus.mac_ready_o);
      end
      @(negedge clk);
      bus.mac_valid_i = 1'b0;
      checks++;
      if (bus.rd_wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL mac_no_same_cycle: got %b exp 0", bus.rd_wr_en_o);
      end
      @(negedge clk);
      wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
      checks++;
      if (wb !== {1'b1, 5'd7, 32'h1234}) begin
         errors++;
         $display("FAIL mac_write: got %h exp %h", wb,
                  {1'b1, 5'd7, 32'h1234});
      end
      checks++;
      if (bus.busy_vec_o !== 32'h80) begin
         errors++;
         $display("FAIL mac_busy_hold: got %h exp 80", bus.busy_vec_o);
      end
      @(negedge clk);
      checks++;
      if ({bus.rd_wr_en_o, bus.busy_vec_o} !== 33'h0) begin
         errors++;
         $display("FAIL mac_busy_clear: got en=%b busy=%h exp 0/0",
                  bus.rd_wr_en_o, bus.busy_vec_o);
      end
   endtask

   task automatic test_starve();
      logic [37:0] wb, exp;
      logic        er;
      int          p;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (k >= 1) begin
            p = k - 1;
            if (p == 9)
               exp = {1'b1, 5'd10, 32'hA0};
            else if (p <= 12)
               exp = {1'b1, 5'd20, 32'(32'h1000 + p)};
            else if (p <= 15)
               exp = {1'b1, 5'(11 + p - 13), 32'(32'hA1 + p - 13)};
            else
               exp = {1'b0, 5'd13, 32'hA3};
            wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
            checks++;
            if (wb !== exp) begin
               errors++;
               $display("FAIL starve_wb[%0d]: got %h exp %h", k, wb, exp);
            end
         end
         if (k <= 12) begin
            er = (k != 9);
            checks++;
            if (bus.alu_ready_o !== er) begin
               errors++;
               $display("FAIL starve_alu_ready[%0d]: got %b exp %b",
                        k, bus.alu_ready_o, er);
            end
         end
         er = !(k >= 4 && k <= 9);
         checks++;
         if (bus.mac_ready_o !== er) begin
            errors++;
            $display("FAIL starve_mac_ready[%0d]: got %b exp %b",
                     k, bus.mac_ready_o, er);
         end
         bus.alu_valid_i   = (k <= 12);
         bus.alu_rd_addr_i = 5'd20;
         bus.alu_rd_data_i = 32'(32'h1000 + k);
         bus.mac_valid_i   = (k < 4);
         bus.mac_rd_addr_i = 5'(10 + k);
         bus.mac_rd_data_i = 32'(32'hA0 + k);
      end
      idle_inputs();
   endtask

   task automatic test_wrap();
      logic [37:0] wb, exp;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            if (k <= 7)
               exp = {1'b1, 5'(1 + k - 2), 32'(32'hB0 + k - 2)};
            else
               exp = {1'b0, 5'd6, 32'hB5};
            wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
            checks++;
            if (wb !== exp) begin
               errors++;
               $display("FAIL wrap_wb[%0d]: got %h exp %h", k, wb, exp);
            end
         end
         checks++;
         if (bus.mac_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_mac_ready[%0d]: got %b exp 1",
                     k, bus.mac_ready_o);
         end
         bus.mac_valid_i   = (k < 6);
         bus.mac_rd_addr_i = 5'(1 + k);
         bus.mac_rd_data_i = 32'(32'hB0 + k);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_drain();
      logic [37:0] wb;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.alu_valid_i      = 1'b1;
         bus.alu_rd_addr_i    = 5'd3;
         bus.alu_rd_data_i    = 32'(32'h3000 + k);
         bus.mac_valid_i      = 1'b1;
         bus.mac_rd_addr_i    = 5'(21 + k);
         bus.mac_rd_data_i    = 32'(32'hC0 + k);
         bus.issue_mac_en_i   = 1'b1;
         bus.issue_mac_addr_i = 5'(21 + k);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
      checks++;
      if (wb !== {1'b1, 5'd21, 32'hC0}) begin
         errors++;
         $display("FAIL drain_first: got %h exp %h", wb,
                  {1'b1, 5'd21, 32'hC0});
      end
      checks++;
      if (bus.busy_vec_o !== 32'h00E0_0000) begin
         errors++;
         $display("FAIL drain_busy: got %h exp 00e00000", bus.busy_vec_o);
      end
      #1 rst = 1'b1;
      #1;
      wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
      checks++;
      if ({wb, bus.busy_vec_o} !== 70'h0) begin
         errors++;
         $display("FAIL async_reset: got wb=%h busy=%h exp 0/0",
                  wb, bus.busy_vec_o);
      end
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus.mac_ready_o, bus.alu_ready_o} !== 2'b11) begin
         errors++;
         $display("FAIL post_reset_ready: got %b exp 11",
                  {bus.mac_ready_o, bus.alu_ready_o});
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         wb = {bus.rd_wr_en_o, bus.rd_addr_o, bus.rd_wr_data_o};
         checks++;
         if (wb !== 38'h0) begin
            errors++;
            $display("FAIL stale_write[%0d]: got %h exp 0", k, wb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_x0();
      test_mac_single();
      test_starve();
      test_wrap();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
